// File: rtl/tt_um_priority_arbiter.sv
// Fixed-priority / round-robin arbiter for eight requesters with a one-cycle release gap.
// Optional grant timeout is compiled in when ARB_TIMEOUT_EN is defined.
module tt_um_priority_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] grant_idx;
    logic [2:0] last_ptr;
    logic [2:0] fp_idx;
    logic [2:0] rr_idx;
    logic [2:0] rr_cand;
    logic [2:0] win_idx;
    logic [2:0] idx_out;
    logic       busy;
    logic       start_grant;
    logic       release_req;
    logic       timeout_hit;
    logic       release_pulse;
    logic       rr_mode;
    logic       unused_bits;

    assign release_pulse = uio_in[7];
    assign rr_mode       = uio_in[6];
    assign unused_bits   = ^uio_in[5:0];

    // Later iterations overwrite earlier ones, so the highest asserted index wins.
    always_comb begin
        fp_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (ui_in[i]) fp_idx = 3'(i);
        end
    end

    // Walk the search order backwards so the candidate closest to last_ptr+1 is kept.
    always_comb begin
        rr_idx  = '0;
        rr_cand = '0;
        for (int i = 7; i >= 0; i--) begin
            rr_cand = last_ptr + 3'(i) + 3'd1;
            if (ui_in[rr_cand]) rr_idx = rr_cand;
        end
    end

    assign win_idx     = rr_mode ? rr_idx : fp_idx;
    assign start_grant = (state == IDLE) && ena && (ui_in != 8'd0);

`ifdef ARB_TIMEOUT_EN
    logic [3:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 4'd1;
        end else begin
            hold_cnt <= '0;
        end
    end

    assign timeout_hit = (hold_cnt == 4'd15);
`else
    assign timeout_hit = 1'b0;
`endif

    assign release_req = !ui_in[grant_idx] || release_pulse || timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_grant) next_state = GRANT;
            GRANT:   if (release_req) next_state = RELEASE;
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // last_ptr resets to 7 so the first round-robin search begins at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx <= '0;
            last_ptr  <= 3'd7;
        end else begin
            if (start_grant) grant_idx <= win_idx;
            if ((state == GRANT) && release_req) last_ptr <= grant_idx;
        end
    end

    always_comb begin
        uo_out  = '0;
        busy    = 1'b0;
        idx_out = '0;
        if (state == GRANT) begin
            uo_out  = 8'd1 << grant_idx;
            busy    = 1'b1;
            idx_out = grant_idx;
        end
    end

    assign uio_out = {2'b00, state, busy, idx_out};
    assign uio_oe  = 8'b0011_1111;

endmodule

// File: tb/tb_tt_um_priority_arbiter.sv
// Directed bench for tt_um_priority_arbiter; grants are scored through an expectation queue.
// Timeout expectations follow ARB_TIMEOUT_EN.
module tb_tt_um_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_exp;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] prev_grant = 8'd0;
    int         hold_cycles;

    logic [7:0] rr_grant[4] = '{8'h01, 8'h80, 8'h01, 8'h80};
    logic [2:0] rr_index[4] = '{3'd0, 3'd7, 3'd0, 3'd7};

    tt_um_priority_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 8'h%h, expected 8'h%h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic n_rst, input logic en, input logic [7:0] req,
                                  input logic rel, input logic mode);
        @(negedge clk);
        rst_n  = n_rst;
        ena    = en;
        ui_in  = req;
        uio_in = {rel, mode, 6'b000000};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [7:0] grant, input logic [2:0] idx);
        exp_q.push_back('{grant: grant, idx: idx});
    endtask

    // Each fresh grant must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (uo_out != 8'd0 && prev_grant == 8'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_grant: got 8'h%h, expected no grant", uo_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("grant_vector", uo_out, mon_exp.grant);
                check_output("grant_index_busy", {4'b0000, uio_out[3:0]}, {4'b0000, 1'b1, mon_exp.idx});
            end
        end
        prev_grant = uo_out;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'h00;
        tick;
        tick;
        check_output("reset_uo_out", uo_out, 8'h00);
        check_output("reset_uio_out", uio_out, 8'h00);
        check_output("reset_uio_oe", uio_oe, 8'h3F);

        // Fixed priority, mode ignored mid-grant, drop of the owner's request
        expect_grant(8'h20, 3'd5);
        apply_stimulus(1'b1, 1'b1, 8'h26, 1'b0, 1'b0);
        tick;
        check_output("fixed_status", uio_out, 8'h1D);
        apply_stimulus(1'b1, 1'b1, 8'h26, 1'b0, 1'b1);
        tick;
        check_output("mode_change_held", uo_out, 8'h20);
        apply_stimulus(1'b1, 1'b1, 8'h06, 1'b0, 1'b1);
        tick;
        check_output("drop_release_status", uio_out, 8'h20);
        check_output("drop_release_uo", uo_out, 8'h00);
        apply_stimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        tick;
        check_output("drop_idle_status", uio_out, 8'h00);

        // Release pulse, then the same requester returns only after the IDLE cycle
        expect_grant(8'h20, 3'd5);
        apply_stimulus(1'b1, 1'b1, 8'h26, 1'b0, 1'b0);
        tick;
        apply_stimulus(1'b1, 1'b1, 8'h26, 1'b1, 1'b0);
        tick;
        check_output("pulse_release_status", uio_out, 8'h20);
        apply_stimulus(1'b1, 1'b1, 8'h26, 1'b0, 1'b0);
        tick;
        check_output("regrant_gap_uo", uo_out, 8'h00);
        check_output("regrant_gap_status", uio_out, 8'h00);
        expect_grant(8'h20, 3'd5);
        tick;
        check_output("regrant_uo", uo_out, 8'h20);
        apply_stimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        tick;
        tick;

        // Round-robin from a fresh reset
        apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        tick;
        expect_grant(rr_grant[0], rr_index[0]);
        apply_stimulus(1'b1, 1'b1, 8'h81, 1'b0, 1'b1);
        tick;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                expect_grant(rr_grant[k], rr_index[k]);
                tick;
            end
            apply_stimulus(1'b1, 1'b1, 8'h81, 1'b1, 1'b1);
            tick;
            apply_stimulus(1'b1, 1'b1, (k == 3) ? 8'h00 : 8'h81, 1'b0, 1'b1);
            tick;
        end

        // Grant hold duration with a request that never drops
        expect_grant(8'h04, 3'd2);
        apply_stimulus(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
        tick;
        hold_cycles = 0;
`ifdef ARB_TIMEOUT_EN
        while (uo_out == 8'h04 && hold_cycles < 40) begin
            hold_cycles++;
            tick;
        end
        check_output("timeout_hold_cycles", 8'(hold_cycles), 8'd16);
        check_output("timeout_release_status", uio_out, 8'h20);
        apply_stimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        tick;
`else
        while (uo_out == 8'h04 && hold_cycles < 100) begin
            hold_cycles++;
            tick;
        end
        check_output("no_timeout_hold_cycles", 8'(hold_cycles), 8'd100);
        apply_stimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        tick;
        check_output("no_timeout_release_status", uio_out, 8'h20);
        tick;
`endif

        // ena gating, then reset in the middle of a grant
        apply_stimulus(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        tick;
        tick;
        tick;
        check_output("ena_low_no_grant", uo_out, 8'h00);
        expect_grant(8'h01, 3'd0);
        apply_stimulus(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        tick;
        apply_stimulus(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        tick;
        check_output("ena_low_grant_kept", uo_out, 8'h01);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("reset_mid_uo_out", uo_out, 8'h00);
        check_output("reset_mid_uio_out", uio_out, 8'h00);
        tick;
        expect_grant(8'h02, 3'd1);
        apply_stimulus(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        tick;
        check_output("first_grant_after_reset", uo_out, 8'h02);
        apply_stimulus(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        tick;
        tick;
        tick;

        check_output("pending_grants", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
